// File: rtl/alu_controller.sv
// Multi-cycle control FSM for a 16-bit ALU datapath: fetch, decode, exec, mem, write-back.
// Owns the PC, instruction register and latched ALU flags; the datapath itself is external.
module alu_controller #(
  parameter int BW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          instr_req,
  output logic [AW-1:0] instr_addr,
  input  logic          instr_valid,
  input  logic [15:0]   instr_data,
  output logic [3:0]    alu_opcode,
  input  logic [2:0]    alu_flags,
  output logic [2:0]    rf_raddr_a,
  output logic [2:0]    rf_raddr_b,
  output logic [2:0]    rf_waddr,
  output logic          rf_wen,
  output logic [1:0]    wb_sel,
  output logic [BW-1:0] imm,
  output logic          mem_req,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic [AW-1:0] pc,
  output logic [2:0]    flags_q,
  output logic          halted,
  output logic          illegal
);

  localparam logic [3:0] OP_MOVA = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_LI   = 4'hA;
  localparam logic [3:0] OP_BR   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_IDLE = 4'hF;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic is_alu;
    logic is_ld;
    logic is_st;
    logic is_li;
    logic is_br;
    logic is_halt;
    logic is_ill;
  } dec_t;

  state_t        state, state_nxt;
  logic [15:0]   ir, ir_nxt;
  logic [AW-1:0] pc_nxt;
  logic [2:0]    flags_nxt;
  logic [3:0]    op;
  logic [2:0]    cond;
  logic          br_taken;
  dec_t          dec;

  assign op   = ir[15:12];
  assign cond = ir[11:9];

  always_comb begin
    dec         = '0;
    dec.is_alu  = ~op[3];
    dec.is_ld   = (op == OP_LD);
    dec.is_st   = (op == OP_ST);
    dec.is_li   = (op == OP_LI);
    dec.is_br   = (op == OP_BR);
    dec.is_halt = (op == OP_HALT);
    dec.is_ill  = (op[3:2] == 2'b11) && (op != OP_HALT);
  end

  // cond==000 is an unconditional branch; otherwise any selected flag set takes it
  assign br_taken = (cond == 3'b000) || ((cond & flags_q) != 3'b000);

  // Register-file addressing and the immediate are pure functions of ir
  assign rf_raddr_a = ir[8:6];
  assign rf_raddr_b = ir[5:3];
  assign rf_waddr   = ir[11:9];
  assign imm        = BW'($signed(ir[8:0]));
  assign instr_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      flags_q <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      flags_q <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    flags_nxt  = flags_q;
    instr_req  = 1'b0;
    alu_opcode = OP_IDLE;
    rf_wen     = 1'b0;
    wb_sel     = WB_ALU;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_nxt    = instr_data;
          pc_nxt    = pc + AW'(1);
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        if (dec.is_alu || dec.is_ld || dec.is_st) begin
          state_nxt = S_EXEC;
        end else if (dec.is_li) begin
          state_nxt = S_WB;
        end else if (dec.is_br) begin
          // pc already points past the branch; offset is relative to that
          if (br_taken) pc_nxt = pc + AW'($signed(ir[8:0]));
          state_nxt = S_FETCH;
        end else if (dec.is_halt) begin
          state_nxt = S_HALT;
        end else begin
          illegal   = dec.is_ill;
          state_nxt = S_FETCH;
        end
      end

      S_EXEC: begin
        if (dec.is_alu) begin
          alu_opcode = op;
          flags_nxt  = alu_flags;
          state_nxt  = S_WB;
        end else if (dec.is_ld || dec.is_st) begin
          alu_opcode = OP_MOVA;
          state_nxt  = S_MEM;
        end else begin
          state_nxt = S_FETCH;
        end
      end

      S_MEM: begin
        // ALU passes reg A through as the data-memory address
        alu_opcode = OP_MOVA;
        mem_req    = 1'b1;
        mem_we     = dec.is_st;
        if (mem_ready) state_nxt = dec.is_ld ? S_WB : S_FETCH;
      end

      S_WB: begin
        rf_wen = 1'b1;
        if (dec.is_ld)      wb_sel = WB_MEM;
        else if (dec.is_li) wb_sel = WB_IMM;
        else                wb_sel = WB_ALU;
        if (dec.is_alu) alu_opcode = op;
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

endmodule

// File: doc/alu_controller.md
Name: alu_controller

Overview:
- Multi-cycle control FSM that sits on the far side of the ALU interface: fetches 16-bit instructions, decodes them, and drives the ALU opcode, register-file controls and data-memory strobes.
- Consumes the ALU `{overflow, negative, zero}` flags and latches them for conditional branches.
- Datapath muxes, register file and memories are external; this block owns only control and the PC.

Parameters:
- BW, 16, datapath width; width of `imm`.
- AW, 8, PC / instruction-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_req  out  1  instruction fetch request; high throughout FETCH.
- instr_addr  out  AW  fetch address; equals pc.
- instr_valid  in  1  instr_data valid; sampled only in FETCH.
- instr_data  in  16  instruction word.
- alu_opcode  out  4  ALU opcode: ADD=0 SUB=1 AND=2 OR=3 XOR=4 INC=5 MOVA=6 MOVB=7; 4'hF = idle (ALU outputs 0).
- alu_flags  in  3  ALU flags; bit2 overflow, bit1 negative, bit0 zero.
- rf_raddr_a  out  3  register-file read port A address.
- rf_raddr_b  out  3  register-file read port B address.
- rf_waddr  out  3  register-file write address.
- rf_wen  out  1  register-file write strobe, 1-cycle pulse.
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 imm.
- imm  out  BW  sign-extended `ir[8:0]`.
- mem_req  out  1  data-memory request; address = ALU output (MOVA of reg A).
- mem_we  out  1  1 = store (data from reg B), 0 = load.
- mem_ready  in  1  memory transfer complete; sampled only in MEM.
- pc  out  AW  program counter.
- flags_q  out  3  latched flags.
- halted  out  1  high in HALT.
- illegal  out  1  1-cycle pulse in DECODE on an opcode in 1100–1110.

Behaviour:
- Encoding: `[15:12]` op.
  - ALU ops 0000–0111: `[11:9]` rd, `[8:6]` ra, `[5:3]` rb.
  - 1000 LD: rd <= mem[ra].
  - 1001 ST: mem[ra] <= rb.
  - 1010 LI: rd <= sext(`[8:0]`).
  - 1011 BR: `[11:9]` cond mask, `[8:0]` signed offset.
  - 1111 HALT.
- Reset values: state=FETCH, pc=0, ir=0, flags_q=0, alu_opcode=4'hF. All strobes (`instr_req` excepted), `halted` and `illegal` are 0. `instr_req` goes high in the first cycle after reset. Reset wins in any state, including mid-fetch and mid-MEM; the pending request is dropped the next cycle.
- FETCH: `instr_req`=1. On `instr_valid`: ir <= instr_data, pc <= pc+1 (wraps mod 2^AW), go to DECODE. Otherwise hold.
- DECODE: `rf_raddr_a` = ir[8:6] and `rf_raddr_b` = ir[5:3] from here through end of instruction. `rf_waddr` = ir[11:9].
  - ALU op, LD, ST -> EXEC.
  - LI -> WB.
  - BR: taken iff cond==000 or (cond & flags_q)!=0. If taken, pc <= pc + sext(off), computed mod 2^AW with pc already incremented. Next state FETCH.
  - HALT -> HALT.
  - 1100–1110: `illegal` pulse, no state change other than pc, -> FETCH.
- EXEC:
  - ALU op: `alu_opcode`=ir[15:12]; flags_q <= alu_flags at end of cycle; -> WB.
  - LD/ST: `alu_opcode`=MOVA; flags_q unchanged; -> MEM.
- MEM: `alu_opcode`=MOVA, `mem_req`=1, `mem_we`=(op==ST). Hold until `mem_ready`; then LD -> WB, ST -> FETCH.
- WB: `rf_wen`=1 for exactly one cycle; -> FETCH.
  - `wb_sel`: ALU op 0, LD 1, LI 2.
  - ALU ops keep `alu_opcode`=ir[15:12] during WB.
- `alu_opcode`=4'hF in every state/op combination not listed above.
- HALT: `halted`=1, all strobes 0; exit only via rst.
- Latency with zero-wait fetch/memory:
  - ALU op: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - LI: 3 cycles.
  - BR: 2 cycles.
  - Each wait cycle of `instr_valid` or `mem_ready` adds one cycle.

Test Plan:
- Reset then `instr_data`=0x0298 (ADD r1,r2,r3), `instr_valid` always 1 -> `alu_opcode`=0 in EXEC and WB; `rf_wen` pulses once in cycle 4 with `rf_waddr`=1, `wb_sel`=0; pc=1.
- SUB with `alu_flags`=3'b101 in EXEC, then BR cond=100 off=-2 (0xB9FE) -> branch taken, pc goes from 2 to 0. Repeat with cond=010 -> not taken, pc=2.
- LD (0x8440) with `mem_ready` held low 3 cycles -> `mem_req`=1 and `mem_we`=0 for 4 cycles, then WB with `wb_sel`=1; ST (0x9050) -> `mem_we`=1, no `rf_wen`.
- LI 0xA3FF -> `imm`=16'hFFFF, `wb_sel`=2, `rf_waddr`=1, 3-cycle instruction; opcode 0xC000 -> `illegal` pulse, no `rf_wen`/`mem_req`.
- Assert rst during MEM wait -> next cycle `mem_req`=0, state FETCH, pc=0, flags_q=0.
- pc=255 fetch -> pc wraps to 0; HALT 0xF000 -> `halted`=1, `instr_req`=0 until rst.
